// File: rtl/svc_axi_arbiter_rd_if.sv
// AXI read-channel bundle (AR + R) for NUM_PORTS lanes; one lane for the shared port, NUM_M for the masters.
// Latency: none, wires only.
// Backpressure: plain AXI valid/ready on AR and R.
interface svc_axi_arbiter_rd_if #(
    parameter int unsigned NUM_PORTS  = 1,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ID_WIDTH   = 4
);
    // AR channel
    logic [NUM_PORTS-1:0]                 arvalid;
    logic [NUM_PORTS-1:0][ID_WIDTH-1:0]   arid;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] araddr;
    logic [NUM_PORTS-1:0][7:0]            arlen;
    logic [NUM_PORTS-1:0][2:0]            arsize;
    logic [NUM_PORTS-1:0][1:0]            arburst;
    logic [NUM_PORTS-1:0]                 arready;

    // R channel
    logic [NUM_PORTS-1:0]                 rvalid;
    logic [NUM_PORTS-1:0][ID_WIDTH-1:0]   rid;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata;
    logic [NUM_PORTS-1:0][1:0]            rresp;
    logic [NUM_PORTS-1:0]                 rlast;
    logic [NUM_PORTS-1:0]                 rready;

    // Side that issues read requests and sinks read data.
    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

    // Side that accepts read requests and returns read data.
    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/svc_axi_arbiter_rd.sv
// Whole-burst AXI read arbiter: NUM_M masters share one downstream read port, one burst in flight.
// Latency: grant registered, so downstream arvalid is 1 cycle after a request; 1 dead IDLE cycle between bursts.
// Backpressure: arready/rready pass straight through to the granted master only; others see 0.
// Build option: define SVC_AXI_ARB_RD_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module svc_axi_arbiter_rd #(
    parameter int unsigned NUM_M          = 2,
    parameter int unsigned AXI_ADDR_WIDTH = 8,
    parameter int unsigned AXI_DATA_WIDTH = 16,
    parameter int unsigned AXI_ID_WIDTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    svc_axi_arbiter_rd_if.slave         s_axi,
    svc_axi_arbiter_rd_if.master        m_axi
);

    localparam int unsigned GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [GW-1:0]   pick;
    logic [GW-1:0]   cand;
    logic            any_req;
    logic            ar_hs;
    logic            r_last_hs;

    assign any_req = |s_axi.arvalid;

`ifdef SVC_AXI_ARB_RD_FIXED_PRIO_EN
    // Fixed priority: scan from the top down so the lowest-index requester is the last write.
    always_comb begin
        pick = '0;
        cand = '0;
        for (int i = int'(NUM_M) - 1; i >= 0; i--) begin
            cand = GW'(i);
            if (s_axi.arvalid[cand]) begin
                pick = cand;
            end
        end
    end
`else
    int rr_idx;

    // Round-robin: walk last_grant+NUM_M down to last_grant+1 so the nearest requester after last_grant wins.
    always_comb begin
        pick   = '0;
        cand   = '0;
        rr_idx = 0;
        for (int i = int'(NUM_M); i >= 1; i--) begin
            rr_idx = (int'(last_grant_q) + i) % int'(NUM_M);
            cand   = GW'(rr_idx);
            if (s_axi.arvalid[cand]) begin
                pick = cand;
            end
        end
    end
`endif

    // Handshakes that move the FSM; both qualified by state so stray valids outside the phase are ignored.
    always_comb begin
        ar_hs     = (state_q == ADDR) && s_axi.arvalid[grant_q] && m_axi.arready[0];
        r_last_hs = (state_q == DATA) && m_axi.rvalid[0] && s_axi.rready[grant_q]
                    && m_axi.rlast[0];
    end

    // Next-state: grant latched on leaving IDLE, pointer advanced only when the burst fully completes.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (ar_hs) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (r_last_hs) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant and fairness pointer; pointer resets to the top index so master 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_M - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Channel muxing: AR only routed in ADDR, R valid/ready only in DATA; R payload always broadcast.
    always_comb begin
        s_axi.arready   = '0;
        s_axi.rvalid    = '0;
        m_axi.arvalid   = '0;
        m_axi.arid      = '0;
        m_axi.araddr    = '0;
        m_axi.arlen     = '0;
        m_axi.arsize    = '0;
        m_axi.arburst   = '0;
        m_axi.rready    = '0;
        for (int i = 0; i < int'(NUM_M); i++) begin
            s_axi.rid[i]   = m_axi.rid[0];
            s_axi.rdata[i] = m_axi.rdata[0];
            s_axi.rresp[i] = m_axi.rresp[0];
            s_axi.rlast[i] = m_axi.rlast[0];
        end
        case (state_q)
            ADDR: begin
                m_axi.arvalid[0]       = s_axi.arvalid[grant_q];
                m_axi.arid[0]          = s_axi.arid[grant_q];
                m_axi.araddr[0]        = s_axi.araddr[grant_q];
                m_axi.arlen[0]         = s_axi.arlen[grant_q];
                m_axi.arsize[0]        = s_axi.arsize[grant_q];
                m_axi.arburst[0]       = s_axi.arburst[grant_q];
                s_axi.arready[grant_q] = m_axi.arready[0];
            end
            DATA: begin
                s_axi.rvalid[grant_q] = m_axi.rvalid[0];
                m_axi.rready[0]       = s_axi.rready[grant_q];
            end
            default: begin
            end
        endcase
    end

    // Only the granted master may ever see arready or rvalid.
    a_arready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(s_axi.arready));
    a_rvalid_onehot:  assert property (@(posedge clk) disable iff (rst) $onehot0(s_axi.rvalid));

    // Downstream AR is never presented outside the address phase.
    a_arvalid_phase:  assert property (@(posedge clk) disable iff (rst)
                                       m_axi.arvalid[0] |-> (state_q == ADDR));

endmodule

// File: tb/tb_svc_axi_arbiter_rd.sv
module tb_svc_axi_arbiter_rd;
    localparam int NUM_M = 2;
    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int IDW   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    svc_axi_arbiter_rd_if #(.NUM_PORTS(NUM_M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW)) s_if ();
    svc_axi_arbiter_rd_if #(.NUM_PORTS(1),     .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW)) m_if ();

    svc_axi_arbiter_rd #(
        .NUM_M(NUM_M), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IDW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .s_axi (s_if),
        .m_axi (m_if)
    );

    int errors = 0;
    int checks = 0;
    int n;
    int nb;
    logic tog;

    // Downstream memory model: after an AR handshake, returns arlen+1 beats with rdata = {id, 4'h0, beat}.
    logic           rsp_busy;
    logic [7:0]     rsp_len;
    logic [7:0]     rsp_beat;
    logic [IDW-1:0] rsp_id;
    logic           smp_ar, smp_r, smp_rst;
    logic [IDW-1:0] smp_id;
    logic [7:0]     smp_len;

    initial begin
        rsp_busy = 1'b0; rsp_len = '0; rsp_beat = '0; rsp_id = '0;
        m_if.rvalid = '0; m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0; m_if.rlast = '0;
        forever begin
            @(negedge clk);
            smp_ar  = m_if.arvalid[0] & m_if.arready[0];
            smp_id  = m_if.arid[0];
            smp_len = m_if.arlen[0];
            smp_r   = m_if.rvalid[0] & m_if.rready[0];
            smp_rst = rst;
            @(posedge clk);
            #1;
            if (smp_rst) begin
                rsp_busy = 1'b0;
            end else begin
                if (smp_r && rsp_busy) begin
                    if (rsp_beat == rsp_len) rsp_busy = 1'b0;
                    else rsp_beat = rsp_beat + 8'd1;
                end
                if (smp_ar) begin
                    rsp_busy = 1'b1; rsp_beat = '0; rsp_len = smp_len; rsp_id = smp_id;
                end
            end
            m_if.rvalid[0] = rsp_busy;
            m_if.rid[0]    = rsp_busy ? rsp_id : '0;
            m_if.rdata[0]  = rsp_busy ? {rsp_id, 4'h0, rsp_beat} : '0;
            m_if.rresp[0]  = 2'b00;
            m_if.rlast[0]  = rsp_busy && (rsp_beat == rsp_len);
        end
    end

    // One cycle forward; inputs are driven at +1 after the edge, outputs sampled a further #1 later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_addr();
        n = 0;
        while (m_if.arvalid[0] !== 1'b1 && n < 10) begin
            cyc(); #1; n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_if.arvalid = 2'b11;
        s_if.rready  = 2'b11;
        repeat (2) cyc();
        #1;
        checks++; if (s_if.arready !== 2'b00) begin errors++; $display("FAIL reset_s_arready: got %b want 00", s_if.arready); end
        checks++; if (s_if.rvalid !== 2'b00) begin errors++; $display("FAIL reset_s_rvalid: got %b want 00", s_if.rvalid); end
        checks++; if (m_if.arvalid[0] !== 1'b0) begin errors++; $display("FAIL reset_m_arvalid: got %b want 0", m_if.arvalid[0]); end
        checks++; if (m_if.rready[0] !== 1'b0) begin errors++; $display("FAIL reset_m_rready: got %b want 0", m_if.rready[0]); end
        checks++; if (dut.state_q !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dut.state_q); end
        cyc();
        rst = 1'b0;
        s_if.arvalid = 2'b00;
    endtask

    task automatic test_single();
        cyc();
        s_if.arid[1] = 4'hD; s_if.araddr[1] = 8'hA0; s_if.arlen[1] = 8'd3;
        s_if.arsize[1] = 3'd1; s_if.arburst[1] = 2'd1;
        s_if.arvalid = 2'b10;
        #1;
        checks++; if (m_if.arvalid[0] !== 1'b0) begin errors++; $display("FAIL single_grant_registered: m_arvalid got %b want 0", m_if.arvalid[0]); end
        cyc(); #1;
        checks++; if (m_if.arvalid[0] !== 1'b1) begin errors++; $display("FAIL single_m_arvalid: got %b want 1", m_if.arvalid[0]); end
        checks++; if (m_if.araddr[0] !== 8'hA0) begin errors++; $display("FAIL single_araddr: got %h want a0", m_if.araddr[0]); end
        checks++; if (m_if.arid[0] !== 4'hD) begin errors++; $display("FAIL single_arid: got %h want d", m_if.arid[0]); end
        checks++; if (m_if.arlen[0] !== 8'd3) begin errors++; $display("FAIL single_arlen: got %0d want 3", m_if.arlen[0]); end
        checks++; if (m_if.arsize[0] !== 3'd1 || m_if.arburst[0] !== 2'd1) begin errors++; $display("FAIL single_arsize_burst: got %0d/%0d want 1/1", m_if.arsize[0], m_if.arburst[0]); end
        checks++; if (s_if.arready !== 2'b10) begin errors++; $display("FAIL single_s_arready: got %b want 10", s_if.arready); end
        cyc();
        s_if.arvalid = 2'b00;
        #1;
        nb = 0;
        for (int c = 0; c < 20 && nb < 4; c++) begin
            checks++; if (s_if.rvalid[0] !== 1'b0) begin errors++; $display("FAIL single_rvalid0_quiet: got %b want 0", s_if.rvalid[0]); end
            if (s_if.rvalid[1] === 1'b1) begin
                checks++; if (s_if.rdata[1] !== 16'hD000 + 16'(nb)) begin errors++; $display("FAIL single_rdata: got %h want %h", s_if.rdata[1], 16'hD000 + 16'(nb)); end
                checks++; if (s_if.rdata[0] !== 16'hD000 + 16'(nb)) begin errors++; $display("FAIL single_rdata_bcast: got %h want %h", s_if.rdata[0], 16'hD000 + 16'(nb)); end
                checks++; if (s_if.rid[1] !== 4'hD) begin errors++; $display("FAIL single_rid: got %h want d", s_if.rid[1]); end
                checks++; if (s_if.rlast[1] !== (nb == 3)) begin errors++; $display("FAIL single_rlast: beat %0d got %b want %b", nb, s_if.rlast[1], (nb == 3)); end
                nb++;
            end
            cyc(); #1;
        end
        checks++; if (nb != 4) begin errors++; $display("FAIL single_beat_count: got %0d want 4", nb); end
        checks++; if (s_if.rvalid !== 2'b00 || m_if.rready[0] !== 1'b0) begin errors++; $display("FAIL single_after_last: rvalid %b rready %b want 00 0", s_if.rvalid, m_if.rready[0]); end
    endtask

    task automatic test_round_robin();
        logic [IDW-1:0] exp_id [4];
        logic [1:0]     exp_rdy[4];
`ifdef SVC_AXI_ARB_RD_FIXED_PRIO_EN
        exp_id  = '{4'h1, 4'h1, 4'h1, 4'h1};
        exp_rdy = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_id  = '{4'h1, 4'h2, 4'h1, 4'h2};
        exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        cyc();
        s_if.arid[0] = 4'h1; s_if.araddr[0] = 8'h10; s_if.arlen[0] = 8'd1;
        s_if.arid[1] = 4'h2; s_if.araddr[1] = 8'h20; s_if.arlen[1] = 8'd1;
        s_if.arvalid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            wait_addr();
            checks++; if (m_if.arvalid[0] !== 1'b1) begin errors++; $display("FAIL rr_timeout: burst %0d no AR within %0d cycles", k, n); end
            checks++; if (n != ((k == 0) ? 1 : 3)) begin errors++; $display("FAIL rr_gap: burst %0d waited %0d want %0d", k, n, (k == 0) ? 1 : 3); end
            checks++; if (m_if.arid[0] !== exp_id[k]) begin errors++; $display("FAIL rr_order: burst %0d arid %h want %h", k, m_if.arid[0], exp_id[k]); end
            checks++; if (s_if.arready !== exp_rdy[k]) begin errors++; $display("FAIL rr_arready: burst %0d got %b want %b", k, s_if.arready, exp_rdy[k]); end
            cyc(); #1;
        end
        s_if.arvalid = 2'b00;
        repeat (4) cyc();
        #1;
        checks++; if (dut.state_q !== 2'd0) begin errors++; $display("FAIL rr_drain_state: got %0d want 0", dut.state_q); end
    endtask

    task automatic test_backpressure();
        cyc();
        s_if.arid[0] = 4'hD; s_if.araddr[0] = 8'h30; s_if.arlen[0] = 8'd3;
        s_if.arvalid = 2'b01;
        s_if.rready  = 2'b10;
        #1;
        wait_addr();
        checks++; if (s_if.arready !== 2'b01) begin errors++; $display("FAIL bp_grant: arready %b want 01", s_if.arready); end
        cyc();
        s_if.arvalid = 2'b00;
        tog = 1'b1;
        nb = 0;
        for (int c = 0; c < 30 && nb < 4; c++) begin
            s_if.rready = {1'b1, tog};
            #1;
            checks++; if (m_if.rready[0] !== tog) begin errors++; $display("FAIL bp_rready_follow: got %b want %b", m_if.rready[0], tog); end
            if (s_if.rvalid[0] === 1'b1 && tog) begin
                checks++; if (s_if.rdata[0] !== 16'hD000 + 16'(nb)) begin errors++; $display("FAIL bp_rdata: got %h want %h", s_if.rdata[0], 16'hD000 + 16'(nb)); end
                checks++; if (s_if.rlast[0] !== (nb == 3)) begin errors++; $display("FAIL bp_rlast: beat %0d got %b", nb, s_if.rlast[0]); end
                nb++;
            end
            tog = ~tog;
            cyc();
        end
        #1;
        checks++; if (nb != 4) begin errors++; $display("FAIL bp_beat_count: got %0d want 4", nb); end
        checks++; if (s_if.rvalid !== 2'b00 || m_if.rready[0] !== 1'b0) begin errors++; $display("FAIL bp_after_last: rvalid %b rready %b want 00 0", s_if.rvalid, m_if.rready[0]); end
        s_if.rready = 2'b11;
    endtask

    task automatic test_wait_during_data();
        cyc();
        s_if.arid[0] = 4'h1; s_if.araddr[0] = 8'h40; s_if.arlen[0] = 8'd1;
        s_if.arid[1] = 4'h2; s_if.araddr[1] = 8'h55; s_if.arlen[1] = 8'd0;
        s_if.arvalid = 2'b01;
        #1;
        wait_addr();
        checks++; if (m_if.arid[0] !== 4'h1) begin errors++; $display("FAIL wd_first_id: got %h want 1", m_if.arid[0]); end
        cyc();
        s_if.arvalid = 2'b10;
        #1;
        checks++; if (m_if.arvalid[0] !== 1'b0 || s_if.arready !== 2'b00) begin errors++; $display("FAIL wd_held_in_data: arvalid %b arready %b want 0 00", m_if.arvalid[0], s_if.arready); end
        n = 0;
        while (!(s_if.rvalid[0] === 1'b1 && s_if.rlast[0] === 1'b1) && n < 10) begin
            cyc(); #1; n++;
        end
        checks++; if (n >= 10) begin errors++; $display("FAIL wd_rlast_timeout: waited %0d cycles", n); end
        cyc(); #1;
        checks++; if (m_if.arvalid[0] !== 1'b0 || s_if.arready !== 2'b00) begin errors++; $display("FAIL wd_dead_cycle: arvalid %b arready %b want 0 00", m_if.arvalid[0], s_if.arready); end
        cyc(); #1;
        checks++; if (m_if.arvalid[0] !== 1'b1) begin errors++; $display("FAIL wd_second_ar: arvalid %b want 1", m_if.arvalid[0]); end
        checks++; if (m_if.arid[0] !== 4'h2 || m_if.araddr[0] !== 8'h55) begin errors++; $display("FAIL wd_second_fields: id %h addr %h want 2 55", m_if.arid[0], m_if.araddr[0]); end
        checks++; if (s_if.arready !== 2'b10) begin errors++; $display("FAIL wd_second_arready: got %b want 10", s_if.arready); end
        cyc();
        s_if.arvalid = 2'b00;
        #1;
        n = 0;
        while (s_if.rvalid[1] !== 1'b1 && n < 10) begin
            cyc(); #1; n++;
        end
        checks++; if (s_if.rdata[1] !== 16'h2000 || s_if.rlast[1] !== 1'b1) begin errors++; $display("FAIL wd_second_beat: rdata %h rlast %b want 2000 1", s_if.rdata[1], s_if.rlast[1]); end
        repeat (2) cyc();
    endtask

    task automatic test_reset_mid_burst();
        cyc();
        s_if.arid[0] = 4'hD; s_if.araddr[0] = 8'h60; s_if.arlen[0] = 8'd3;
        s_if.arvalid = 2'b01;
        #1;
        wait_addr();
        cyc();
        s_if.arvalid = 2'b00;
        #1;
        nb = 0;
        for (int c = 0; c < 10 && nb < 2; c++) begin
            if (s_if.rvalid[0] === 1'b1) nb++;
            cyc(); #1;
        end
        checks++; if (nb != 2) begin errors++; $display("FAIL rm_two_beats: got %0d want 2", nb); end
        rst = 1'b1;
        cyc(); #1;
        checks++; if (s_if.rvalid !== 2'b00 || m_if.rready[0] !== 1'b0) begin errors++; $display("FAIL rm_r_cleared: rvalid %b rready %b want 00 0", s_if.rvalid, m_if.rready[0]); end
        checks++; if (m_if.arvalid[0] !== 1'b0 || s_if.arready !== 2'b00) begin errors++; $display("FAIL rm_ar_cleared: arvalid %b arready %b want 0 00", m_if.arvalid[0], s_if.arready); end
        checks++; if (dut.state_q !== 2'd0) begin errors++; $display("FAIL rm_state: got %0d want 0", dut.state_q); end
        rst = 1'b0;
        cyc();
        s_if.arid[1] = 4'h3; s_if.araddr[1] = 8'h70; s_if.arlen[1] = 8'd0;
        s_if.arvalid = 2'b10;
        #1;
        wait_addr();
        checks++; if (m_if.arid[0] !== 4'h3 || m_if.araddr[0] !== 8'h70 || s_if.arready !== 2'b10) begin errors++; $display("FAIL rm_new_ar: id %h addr %h arready %b want 3 70 10", m_if.arid[0], m_if.araddr[0], s_if.arready); end
        cyc();
        s_if.arvalid = 2'b00;
        #1;
        n = 0;
        while (s_if.rvalid[1] !== 1'b1 && n < 10) begin
            cyc(); #1; n++;
        end
        checks++; if (s_if.rdata[1] !== 16'h3000 || s_if.rlast[1] !== 1'b1 || s_if.rvalid[0] !== 1'b0) begin errors++; $display("FAIL rm_new_beat: rdata %h rlast %b rvalid %b want 3000 1 10", s_if.rdata[1], s_if.rlast[1], s_if.rvalid); end
        repeat (2) cyc();
    endtask

    initial begin
        rst = 1'b1;
        s_if.arvalid = '0; s_if.arid = '0; s_if.araddr = '0; s_if.arlen = '0;
        s_if.arsize = '0; s_if.arburst = '0; s_if.rready = '0;
        m_if.arready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wait_during_data();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
